// File: rtl/seg_scan_pkg.sv
// Package for the multiplexed 7-segment scanner.
// Holds the slot state enum, the glyph constants in positive-logic
// {g,f,e,d,c,b,a} order, and the nibble-to-glyph decode function.
package seg_scan_pkg;

  // Slot phases: dead time first, then the driven part of the slot.
  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } seg_state_e;

  // Glyphs, bit order {g,f,e,d,c,b,a}, 1 = segment lit.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;

  // Code 0xA is a dash and 0xB is blank; 0xC..0xF are hex letters.
  function automatic logic [6:0] seg7_glyph(input logic [3:0] code);
    logic [6:0] g;
    g = SEG_BLANK;
    case (code)
      4'h0: g = SEG_0;
      4'h1: g = SEG_1;
      4'h2: g = SEG_2;
      4'h3: g = SEG_3;
      4'h4: g = SEG_4;
      4'h5: g = SEG_5;
      4'h6: g = SEG_6;
      4'h7: g = SEG_7;
      4'h8: g = SEG_8;
      4'h9: g = SEG_9;
      4'hA: g = SEG_DASH;
      4'hB: g = SEG_BLANK;
      4'hC: g = SEG_HEX_C;
      4'hD: g = SEG_HEX_D;
      4'hE: g = SEG_HEX_E;
      4'hF: g = SEG_HEX_F;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble + decimal point to 8-bit positive-logic segments.
// Ports:
//   code_i  4-bit digit code
//   dp_i    decimal point request
//   seg_o   {dp,g,f,e,d,c,b,a}, 1 = lit
module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  assign seg_o = {dp_i, seg7_glyph(code_i)};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner.
// Each digit owns a slot of SLOT_CYC cycles: BLANK_CYC cycles of dead time
// (everything dark, glyph free to change) followed by the driven part, in
// which the anode is PWM-gated by the brightness value. All display inputs
// are captured once per frame as digit 0's slot begins, so a frame always
// shows one consistent picture.
//
// Optional feature: define SEG_SCAN_LZ_EN to build leading-zero suppression
// (controlled by lz_en). Without it lz_en is accepted and ignored.
//
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   digits         4 bits per digit, digit 0 rightmost
//   dp             decimal point per digit (1 = lit)
//   blank_mask     1 = digit forced dark
//   blink_en       global blink enable
//   blink_mask     1 = digit blinks while blink_en
//   brightness     PWM duty, all-ones = full
//   lz_en          leading-zero suppression request
//   an             anode enables (polarity AN_ACTIVE_LOW)
//   seg            {dp,g,f,e,d,c,b,a} (polarity SEG_ACTIVE_LOW)
//   digit_idx      digit owning the current slot
//   frame_tick     one-cycle pulse when digit 0's slot begins
//   dbg_state      internal slot state (BLANK/DRIVE)
//
// Handshake note: there is no valid/ready traffic here; inputs are sampled
// level-wise at frame start and outputs are free-running registered levels.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int SLOT_CYC       = 100000,
  parameter int BLANK_CYC      = 1000,
  parameter int BLINK_HALF_CYC = 25000000,
  parameter int BRIGHT_W       = 3,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  blink_en,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic [BRIGHT_W-1:0]   brightness,
  input  logic                  lz_en,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic [IW-1:0]         digit_idx,
  output logic                  frame_tick,
  output seg_state_e            dbg_state
);

  localparam int CW  = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int BKW = (BLINK_HALF_CYC > 1) ? $clog2(BLINK_HALF_CYC) : 1;

  localparam logic [CW-1:0]     SLOT_LAST  = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0]     BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [BKW-1:0]    BLINK_LAST = BKW'(BLINK_HALF_CYC - 1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF     = {DIGITS{AN_ACTIVE_LOW != 0}};
  localparam logic [7:0]        SEG_OFF    = {8{SEG_ACTIVE_LOW != 0}};

  // Scan state
  logic                run_q, run_d;
  seg_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [BRIGHT_W-1:0] pwm_q, pwm_d;
  logic [BKW-1:0]      blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic                snap_load;

  // Frame snapshot
  logic [4*DIGITS-1:0] snap_digits_q, snap_digits_d;
  logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [DIGITS-1:0]   snap_blank_q, snap_blank_d;
  logic                snap_blink_en_q, snap_blink_en_d;
  logic [DIGITS-1:0]   snap_blink_mask_q, snap_blink_mask_d;
  logic [BRIGHT_W-1:0] snap_bright_q, snap_bright_d;
  logic                snap_phase_q, snap_phase_d;

  // Registered outputs
  logic [DIGITS-1:0]   an_q, an_d;
  logic [7:0]          seg_q, seg_d;
  logic [IW-1:0]       digit_idx_q, digit_idx_d;
  logic                frame_tick_q, frame_tick_d;

  // Datapath
  logic [DIGITS-1:0]   dark;
  logic [3:0]          cur_code;
  logic                cur_dp;
  logic                cur_dark;
  logic [DIGITS-1:0]   cur_onehot;
  logic [7:0]          cur_seg;
  logic [DIGITS-1:0]   an_pos;
  logic [7:0]          seg_pos;

`ifdef SEG_SCAN_LZ_EN
  logic                snap_lz_q, snap_lz_d;
  logic [DIGITS-1:0]   lz_mask;
  logic                lz_run;
`else
  logic                unused_lz;
  assign unused_lz = lz_en;
`endif

  // Slot sequencing. The first cycle out of reset enters slot 0 at count 0
  // without advancing, so the snapshot load and the count both line up with
  // "slot 0 begins" on that edge.
  always_comb begin
    run_d     = 1'b1;
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    pwm_d     = pwm_q;
    snap_load = 1'b0;
    if (!run_q) begin
      snap_load = 1'b1;
    end else if (cnt_q == SLOT_LAST) begin
      cnt_d     = '0;
      state_d   = BLANK;
      idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      snap_load = (idx_q == IDX_LAST);
    end else begin
      cnt_d = cnt_q + CW'(1);
      if (state_q == BLANK && cnt_q == BLANK_LAST) begin
        state_d = DRIVE;
        pwm_d   = '0;
      end else if (state_q == DRIVE) begin
        pwm_d = pwm_q + BRIGHT_W'(1);
      end
    end
  end

  // Free-running blink phase; only the copy taken at frame start matters.
  always_comb begin
    blink_cnt_d = blink_cnt_q + BKW'(1);
    phase_d     = phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_comb begin
    snap_digits_d     = snap_digits_q;
    snap_dp_d         = snap_dp_q;
    snap_blank_d      = snap_blank_q;
    snap_blink_en_d   = snap_blink_en_q;
    snap_blink_mask_d = snap_blink_mask_q;
    snap_bright_d     = snap_bright_q;
    snap_phase_d      = snap_phase_q;
    if (snap_load) begin
      snap_digits_d     = digits;
      snap_dp_d         = dp;
      snap_blank_d      = blank_mask;
      snap_blink_en_d   = blink_en;
      snap_blink_mask_d = blink_mask;
      snap_bright_d     = brightness;
      snap_phase_d      = phase_q;
    end
  end

`ifdef SEG_SCAN_LZ_EN
  always_comb begin
    snap_lz_d = snap_lz_q;
    if (snap_load) snap_lz_d = lz_en;
  end

  // Walk down from the leftmost digit, suppressing zeros until the first
  // non-zero code. Digit 0 is outside the walk so a lone 0 still shows.
  always_comb begin
    lz_mask = '0;
    lz_run  = snap_lz_q;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (lz_run && snap_digits_q[4*k +: 4] == 4'h0) begin
        lz_mask[k] = 1'b1;
      end else begin
        lz_run = 1'b0;
      end
    end
  end
`endif

  always_comb begin
    dark = snap_blank_q;
    if (snap_blink_en_q && !snap_phase_q) dark = dark | snap_blink_mask_q;
`ifdef SEG_SCAN_LZ_EN
    dark = dark | lz_mask;
`endif
  end

  // Select the slot owner's code, dp and darkness from the snapshot.
  always_comb begin
    cur_code   = 4'h0;
    cur_dp     = 1'b0;
    cur_dark   = 1'b1;
    cur_onehot = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_code      = snap_digits_q[4*k +: 4];
        cur_dp        = snap_dp_q[k];
        cur_dark      = dark[k];
        cur_onehot[k] = 1'b1;
      end
    end
  end

  seg7_decode u_decode (
    .code_i (cur_code),
    .dp_i   (cur_dp),
    .seg_o  (cur_seg)
  );

  // The glyph is held for the whole DRIVE window (PWM only gates the anode),
  // so segment lines change only at BLANK boundaries.
  always_comb begin
    an_pos  = '0;
    seg_pos = '0;
    if (state_q == DRIVE && !cur_dark) begin
      seg_pos = cur_seg;
      if (pwm_q <= snap_bright_q) an_pos = cur_onehot;
    end
    an_d         = an_pos ^ AN_OFF;
    seg_d        = seg_pos ^ SEG_OFF;
    digit_idx_d  = idx_q;
    frame_tick_d = run_q && state_q == BLANK && cnt_q == '0 && idx_q == '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_q             <= 1'b0;
      state_q           <= BLANK;
      cnt_q             <= '0;
      idx_q             <= '0;
      pwm_q             <= '0;
      blink_cnt_q       <= '0;
      phase_q           <= 1'b1;
      snap_digits_q     <= '0;
      snap_dp_q         <= '0;
      snap_blank_q      <= '1;
      snap_blink_en_q   <= 1'b0;
      snap_blink_mask_q <= '0;
      snap_bright_q     <= '0;
      snap_phase_q      <= 1'b1;
`ifdef SEG_SCAN_LZ_EN
      snap_lz_q         <= 1'b0;
`endif
      an_q              <= AN_OFF;
      seg_q             <= SEG_OFF;
      digit_idx_q       <= '0;
      frame_tick_q      <= 1'b0;
    end else begin
      run_q             <= run_d;
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      idx_q             <= idx_d;
      pwm_q             <= pwm_d;
      blink_cnt_q       <= blink_cnt_d;
      phase_q           <= phase_d;
      snap_digits_q     <= snap_digits_d;
      snap_dp_q         <= snap_dp_d;
      snap_blank_q      <= snap_blank_d;
      snap_blink_en_q   <= snap_blink_en_d;
      snap_blink_mask_q <= snap_blink_mask_d;
      snap_bright_q     <= snap_bright_d;
      snap_phase_q      <= snap_phase_d;
`ifdef SEG_SCAN_LZ_EN
      snap_lz_q         <= snap_lz_d;
`endif
      an_q              <= an_d;
      seg_q             <= seg_d;
      digit_idx_q       <= digit_idx_d;
      frame_tick_q      <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign digit_idx  = digit_idx_q;
  assign frame_tick = frame_tick_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with a small active-low 4-digit configuration.
// The reference model works from the frame/slot/cycle position since reset
// release and a per-frame copy of the inputs, and predicts every output
// cycle. Expected words go through exp_q and are checked each cycle.
module tb_seg_scan_ctrl;

  localparam int DIGITS         = 4;
  localparam int SLOT_CYC       = 16;
  localparam int BLANK_CYC      = 2;
  localparam int BLINK_HALF_CYC = 64;
  localparam int BRIGHT_W       = 2;
  localparam int IW             = 2;
  localparam int FRAME          = DIGITS * SLOT_CYC;
  localparam int EW             = DIGITS + 8 + IW + 1;

`ifdef SEG_SCAN_LZ_EN
  localparam bit LZ_BUILD = 1'b1;
`else
  localparam bit LZ_BUILD = 1'b0;
`endif

  logic                  clk;
  logic                  reset_n;
  logic [4*DIGITS-1:0]   digits;
  logic [DIGITS-1:0]     dp;
  logic [DIGITS-1:0]     blank_mask;
  logic                  blink_en;
  logic [DIGITS-1:0]     blink_mask;
  logic [BRIGHT_W-1:0]   brightness;
  logic                  lz_en;
  logic [DIGITS-1:0]     an;
  logic [7:0]            seg;
  logic [IW-1:0]         digit_idx;
  logic                  frame_tick;
  seg_scan_pkg::seg_state_e dbg_state;

  seg_scan_ctrl #(
    .DIGITS         (DIGITS),
    .SLOT_CYC       (SLOT_CYC),
    .BLANK_CYC      (BLANK_CYC),
    .BLINK_HALF_CYC (BLINK_HALF_CYC),
    .BRIGHT_W       (BRIGHT_W),
    .AN_ACTIVE_LOW  (1),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .digits     (digits),
    .dp         (dp),
    .blank_mask (blank_mask),
    .blink_en   (blink_en),
    .blink_mask (blink_mask),
    .brightness (brightness),
    .lz_en      (lz_en),
    .an         (an),
    .seg        (seg),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Positive-logic {g,f,e,d,c,b,a} glyphs for codes 0..F.
  logic [6:0] glyph_tab [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h00, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic [4*DIGITS-1:0] m_digits;
  logic [DIGITS-1:0]   m_dp, m_blank, m_blink_mask;
  logic                m_blink_en, m_lz, m_phase;
  logic [BRIGHT_W-1:0] m_bright;
  int                  edge_cnt;
  int                  last_m;
  logic [EW-1:0]       exp_q[$];
  int                  checks;
  int                  errors;

  function automatic bit model_dark(int k);
    int top;
    bit lzs;
    top = 0;
    for (int i = 0; i < DIGITS; i++) if (m_digits[4*i +: 4] != 4'h0) top = i;
    lzs = LZ_BUILD && m_lz && (k > 0) && (k > top);
    return m_blank[k] || (m_blink_en && m_blink_mask[k] && !m_phase) || lzs;
  endfunction

  // Output expected after the m-th edge since reset release (edge 0 first).
  // It reflects the scan position reached at edge m-1.
  function automatic logic [EW-1:0] model_out(int m);
    int s, p, d, c, j;
    logic [DIGITS-1:0] e_an;
    logic [7:0]        e_seg;
    logic [IW-1:0]     e_idx;
    logic              e_tick;
    logic [7:0]        lit;
    e_an   = '1;
    e_seg  = 8'hFF;
    e_idx  = '0;
    e_tick = 1'b0;
    if (m > 0) begin
      s      = m - 1;
      p      = s % FRAME;
      d      = p / SLOT_CYC;
      c      = p % SLOT_CYC;
      e_idx  = IW'(d);
      e_tick = (p == 0);
      if (c >= BLANK_CYC && !model_dark(d)) begin
        lit   = {m_dp[d], glyph_tab[m_digits[4*d +: 4]]};
        e_seg = ~lit;
        j     = c - BLANK_CYC;
        if ((j % (1 << BRIGHT_W)) <= int'(m_bright)) e_an = ~(DIGITS'(1) << d);
      end
    end
    return {e_an, e_seg, e_idx, e_tick};
  endfunction

  task automatic model_edge();
    int m;
    if (!reset_n) begin
      exp_q.push_back(model_out(0));
      last_m       = -1;
      edge_cnt     = 0;
      m_digits     = '0;
      m_dp         = '0;
      m_blank      = '1;
      m_blink_en   = 1'b0;
      m_blink_mask = '0;
      m_bright     = '0;
      m_lz         = 1'b0;
      m_phase      = 1'b1;
    end else begin
      m      = edge_cnt;
      last_m = m;
      exp_q.push_back(model_out(m));
      if (m % FRAME == 0) begin
        m_digits     = digits;
        m_dp         = dp;
        m_blank      = blank_mask;
        m_blink_en   = blink_en;
        m_blink_mask = blink_mask;
        m_bright     = brightness;
        m_lz         = lz_en;
        m_phase      = ((m / BLINK_HALF_CYC) % 2) == 0;
      end
      edge_cnt++;
    end
  endtask

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    logic [EW-1:0]     e;
    logic [DIGITS-1:0] e_an;
    logic [7:0]        e_seg;
    logic [IW-1:0]     e_idx;
    logic              e_tick;
    @(posedge clk);
    model_edge();
    #1;
    e = exp_q.pop_front();
    {e_an, e_seg, e_idx, e_tick} = e;
    checks++;
    assert (an === e_an) else begin
      errors++;
      $error("FAIL an m=%0d got=%b exp=%b", last_m, an, e_an);
    end
    checks++;
    assert (seg === e_seg) else begin
      errors++;
      $error("FAIL seg m=%0d got=%h exp=%h", last_m, seg, e_seg);
    end
    checks++;
    assert (digit_idx === e_idx) else begin
      errors++;
      $error("FAIL digit_idx m=%0d got=%0d exp=%0d", last_m, digit_idx, e_idx);
    end
    checks++;
    assert (frame_tick === e_tick) else begin
      errors++;
      $error("FAIL frame_tick m=%0d got=%b exp=%b", last_m, frame_tick, e_tick);
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the next edge to come is frame position pos.
  task automatic run_to(int pos);
    int guard;
    guard = 0;
    while ((edge_cnt % FRAME) != pos && guard < 2 * FRAME) begin
      step();
      guard++;
    end
  endtask

  task automatic set_inputs(logic [15:0] d, logic [3:0] p, logic [3:0] bm,
                            logic be, logic [3:0] bkm, logic [1:0] br, logic lz);
    digits     = d;
    dp         = p;
    blank_mask = bm;
    blink_en   = be;
    blink_mask = bkm;
    brightness = br;
    lz_en      = lz;
  endtask

  task automatic rand_inputs();
    for (int k = 0; k < DIGITS; k++)
      digits[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    dp         = 4'($urandom_range(0, 15));
    blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
    blink_en   = 1'($urandom_range(0, 1));
    blink_mask = 4'($urandom_range(0, 15));
    brightness = 2'($urandom_range(0, 3));
    lz_en      = 1'($urandom_range(0, 1));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    checks   = 0;
    errors   = 0;
    edge_cnt = 0;
    last_m   = -1;
    reset_n  = 1'b0;
    set_inputs(16'h0000, 4'h0, 4'h0, 1'b0, 4'h0, 2'd3, 1'b0);

    // Reset state
    run(3);
    reset_n = 1'b1;

    // Scan order, full brightness
    set_inputs(16'h4321, 4'h0, 4'h0, 1'b0, 4'h0, 2'd3, 1'b0);
    run(2 * FRAME + 2);

    // Half duty, with decimal points and a blanked digit
    set_inputs(16'h4321, 4'h5, 4'h4, 1'b0, 4'h0, 2'd1, 1'b0);
    run(FRAME + 4);

    // Blink on digit 0 across several frames
    set_inputs(16'h8A9B, 4'h0, 4'h0, 1'b1, 4'h1, 2'd3, 1'b0);
    run(5 * FRAME);

    // Mid-frame change waits for the next frame
    set_inputs(16'h1111, 4'h0, 4'h0, 1'b0, 4'h0, 2'd3, 1'b0);
    run_to(0);
    run_to(2 * SLOT_CYC + 4);
    digits = 16'h2222;
    run(FRAME + 8);

    // Leading zeros (suppressed only in the LZ build)
    set_inputs(16'h0050, 4'hF, 4'h0, 1'b0, 4'h0, 2'd3, 1'b1);
    run_to(0);
    run(FRAME + 2);
    digits = 16'h0000;
    run_to(0);
    run(FRAME + 2);

    // Brightness 0 and hex glyphs
    set_inputs(16'hFEDC, 4'h0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0);
    run(FRAME + 4);

    // Randomized segments of input activity
    for (int r = 0; r < 12; r++) begin
      rand_inputs();
      run($urandom_range(10, 100));
    end

    // Reset pulse during a DRIVE window
    set_inputs(16'h4321, 4'h0, 4'h0, 1'b0, 4'h0, 2'd3, 1'b0);
    run_to(0);
    run_to(SLOT_CYC + 6);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    run(FRAME + 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
